// File: rtl/bram_dp_init.sv
// True dual-port RAM wrapper: registered inputs, optional output register,
// selectable same-port read-during-write, collision flag and post-reset zero fill.

module generic_sram #(
  parameter int abits = 14,
  parameter int dbits = 1
) (
  input  logic             clk,
  input  logic [abits-1:0] a0,
  input  logic [dbits-1:0] d0,
  input  logic             we0,
  input  logic             re0,
  output logic [dbits-1:0] q0,
  input  logic [abits-1:0] a1,
  input  logic [dbits-1:0] d1,
  input  logic             we1,
  input  logic             re1,
  output logic [dbits-1:0] q1
);

  logic [dbits-1:0] mem [0:(1<<abits)-1];

  // Reads see pre-edge contents; port 0 write is scheduled last so it wins a tie.
  always_ff @(posedge clk) begin
    if (re0) q0 <= mem[a0];
    if (re1) q1 <= mem[a1];
    if (we1) mem[a1] <= d1;
    if (we0) mem[a0] <= d0;
  end

endmodule

module bram_dp_init #(
  parameter int ABITS      = 14,
  parameter int DBITS      = 1,
  parameter int WMODE      = 0,
  parameter int OREG       = 0,
  parameter int INIT_CLEAR = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [ABITS-1:0] A0,
  input  logic [DBITS-1:0] D0,
  output logic [DBITS-1:0] Q0,
  input  logic             WE0,
  input  logic             CE0,
  input  logic [ABITS-1:0] A1,
  input  logic [DBITS-1:0] D1,
  output logic [DBITS-1:0] Q1,
  input  logic             WE1,
  input  logic             CE1,
  output logic             READY,
  output logic             COLL
);

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;
  localparam logic [0:0] S_INIT  = (INIT_CLEAR != 0) ? S_CLEAR : S_RUN;
  localparam bit         WF      = (WMODE != 0);

  logic [0:0]       state;
  logic [ABITS-1:0] cnt;
  logic             clr;

  assign clr = (state == S_CLEAR);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_INIT;
      cnt   <= '0;
      READY <= 1'b0;
    end else begin
      READY <= (state == S_RUN);
      if (clr) begin
        cnt <= cnt + ABITS'(1);
        if (&cnt) state <= S_RUN;
      end
    end
  end

  // Stage p0: sample user request; anything offered before READY is dropped here.
  logic [ABITS-1:0] a0_p0, a1_p0;
  logic [DBITS-1:0] d0_p0, d1_p0;
  logic             we0_p0, we1_p0, vld0_p0, vld1_p0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a0_p0   <= '0;
      a1_p0   <= '0;
      d0_p0   <= '0;
      d1_p0   <= '0;
      we0_p0  <= 1'b0;
      we1_p0  <= 1'b0;
      vld0_p0 <= 1'b0;
      vld1_p0 <= 1'b0;
    end else begin
      a0_p0   <= A0;
      a1_p0   <= A1;
      d0_p0   <= D0;
      d1_p0   <= D1;
      we0_p0  <= WE0 & CE0 & READY;
      we1_p0  <= WE1 & CE1 & READY;
      vld0_p0 <= CE0 & READY & (!WE0 | WF);
      vld1_p0 <= CE1 & READY & (!WE1 | WF);
    end
  end

  // Stage p1: RAM access; the clear sequencer borrows port 0 while READY is low.
  logic [ABITS-1:0] ram_a0;
  logic [DBITS-1:0] ram_d0, ram_q0, ram_q1;
  logic             ram_we0, ram_re0, ram_re1;

  assign ram_a0  = clr ? cnt : a0_p0;
  assign ram_d0  = clr ? '0 : d0_p0;
  assign ram_we0 = clr | we0_p0;
  assign ram_re0 = vld0_p0 & !we0_p0;
  assign ram_re1 = vld1_p0 & !we1_p0;

  generic_sram #(
    .abits (ABITS),
    .dbits (DBITS)
  ) u_sram (
    .clk (CLK),
    .a0  (ram_a0),
    .d0  (ram_d0),
    .we0 (ram_we0),
    .re0 (ram_re0),
    .q0  (ram_q0),
    .a1  (a1_p0),
    .d1  (d1_p0),
    .we1 (we1_p0),
    .re1 (ram_re1),
    .q1  (ram_q1)
  );

  logic             vld0_p1, vld1_p1, wf0_p1, wf1_p1;
  logic [DBITS-1:0] wd0_p1, wd1_p1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld0_p1 <= 1'b0;
      vld1_p1 <= 1'b0;
      wf0_p1  <= 1'b0;
      wf1_p1  <= 1'b0;
      COLL    <= 1'b0;
    end else begin
      vld0_p1 <= vld0_p0;
      vld1_p1 <= vld1_p0;
      wf0_p1  <= we0_p0;
      wf1_p1  <= we1_p0;
      COLL    <= we0_p0 & we1_p0 & (a0_p0 == a1_p0);
    end
  end

  always_ff @(posedge CLK) begin
    wd0_p1 <= d0_p0;
    wd1_p1 <= d1_p0;
  end

  // Stage p2: result register; a write-first cycle returns the written data.
  logic [DBITS-1:0] q0_p2, q1_p2;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q0_p2 <= '0;
      q1_p2 <= '0;
    end else begin
      if (vld0_p1) q0_p2 <= wf0_p1 ? wd0_p1 : ram_q0;
      if (vld1_p1) q1_p2 <= wf1_p1 ? wd1_p1 : ram_q1;
    end
  end

  // Stage p3: optional output register for timing closure.
  generate
    if (OREG != 0) begin : g_oreg
      logic [DBITS-1:0] q0_p3, q1_p3;

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          q0_p3 <= '0;
          q1_p3 <= '0;
        end else begin
          q0_p3 <= q0_p2;
          q1_p3 <= q1_p2;
        end
      end

      assign Q0 = q0_p3;
      assign Q1 = q1_p3;
    end else begin : g_noreg
      assign Q0 = q0_p2;
      assign Q1 = q1_p2;
    end
  endgenerate

endmodule

// File: tb/tb_bram_dp_init.sv
// Bench for bram_dp_init: two configurations driven in lockstep and checked
// every cycle against a memory/latency model, plus literal spot checks.

module tb_bram_dp_init;

  localparam int AB    = 4;
  localparam int DB    = 8;
  localparam int DEPTH = 16;

  logic          clk, rst;
  logic [AB-1:0] a0, a1;
  logic [DB-1:0] d0, d1;
  logic          we0, ce0, we1, ce1;
  logic [DB-1:0] qa0, qa1, qb0, qb1;
  logic          rdya, rdyb, colla, collb;

  int errors;
  int checks;
  bit check_en;

  // dut_a: read-first, no output register; dut_b: write-first, output register.
  bram_dp_init #(.ABITS(AB), .DBITS(DB), .WMODE(0), .OREG(0), .INIT_CLEAR(1)) dut_a (
    .CLK(clk), .RST(rst),
    .A0(a0), .D0(d0), .Q0(qa0), .WE0(we0), .CE0(ce0),
    .A1(a1), .D1(d1), .Q1(qa1), .WE1(we1), .CE1(ce1),
    .READY(rdya), .COLL(colla));

  bram_dp_init #(.ABITS(AB), .DBITS(DB), .WMODE(1), .OREG(1), .INIT_CLEAR(1)) dut_b (
    .CLK(clk), .RST(rst),
    .A0(a0), .D0(d0), .Q0(qb0), .WE0(we0), .CE0(ce0),
    .A1(a1), .D1(d1), .Q1(qb1), .WE1(we1), .CE1(ce1),
    .READY(rdyb), .COLL(collb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: flat memory, READY from edge count, results scheduled by read latency.
  logic [DB-1:0] mmem [DEPTH];
  int            edges;
  bit            m_ready;
  bit            exp_coll;
  logic [DB-1:0] exp_q [2][2];
  bit            sv [2][2][8];
  logic [DB-1:0] sd [2][2][8];
  bit            cv [8];
  int            slot, tgt;
  logic [DB-1:0] rd0, rd1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      edges    = 0;
      m_ready  = 1'b0;
      exp_coll = 1'b0;
      for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
      for (int k = 0; k < 2; k++)
        for (int p = 0; p < 2; p++) begin
          exp_q[k][p] = '0;
          for (int s = 0; s < 8; s++) sv[k][p][s] = 1'b0;
        end
      for (int s = 0; s < 8; s++) cv[s] = 1'b0;
    end else begin
      edges++;
      slot     = edges % 8;
      exp_coll = cv[slot];
      cv[slot] = 1'b0;
      for (int k = 0; k < 2; k++)
        for (int p = 0; p < 2; p++)
          if (sv[k][p][slot]) begin
            exp_q[k][p]    = sd[k][p][slot];
            sv[k][p][slot] = 1'b0;
          end
      if (m_ready) begin
        rd0 = mmem[a0];
        rd1 = mmem[a1];
        for (int k = 0; k < 2; k++) begin
          tgt = (edges + ((k == 0) ? 2 : 3)) % 8;
          if (ce0 && (!we0 || k == 1)) begin
            sv[k][0][tgt] = 1'b1;
            sd[k][0][tgt] = we0 ? d0 : rd0;
          end
          if (ce1 && (!we1 || k == 1)) begin
            sv[k][1][tgt] = 1'b1;
            sd[k][1][tgt] = we1 ? d1 : rd1;
          end
        end
        if (ce0 && we0 && ce1 && we1 && a0 == a1) cv[(edges + 1) % 8] = 1'b1;
        if (ce1 && we1) mmem[a1] = d1;
        if (ce0 && we0) mmem[a0] = d0;
      end
      m_ready = (edges >= DEPTH + 1);
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("ready_a", rdya, m_ready);
      check("ready_b", rdyb, m_ready);
      check("coll_a", colla, exp_coll);
      check("coll_b", collb, exp_coll);
      check("q0_a", qa0, exp_q[0][0]);
      check("q1_a", qa1, exp_q[0][1]);
      check("q0_b", qb0, exp_q[1][0]);
      check("q1_b", qb1, exp_q[1][1]);
    end
  end

  task automatic drive(input logic c0, input logic w0, input logic [AB-1:0] av0, input logic [DB-1:0] dv0,
                       input logic c1, input logic w1, input logic [AB-1:0] av1, input logic [DB-1:0] dv1);
    ce0 = c0; we0 = w0; a0 = av0; d0 = dv0;
    ce1 = c1; we1 = w1; a1 = av1; d1 = dv1;
    @(posedge clk); #1;
    ce0 = 1'b0; we0 = 1'b0; ce1 = 1'b0; we1 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic release_and_clear(input bit inject);
    rst = 1'b0;
    for (int i = 1; i <= DEPTH + 1; i++) begin
      if (inject && i == 5) begin
        ce0 = 1'b1; we0 = 1'b1; a0 = 4'd2; d0 = 8'hFF;
      end
      @(posedge clk); #1;
      if (i == DEPTH) begin
        check("ready_a_edge16", rdya, 32'd0);
        check("ready_b_edge16", rdyb, 32'd0);
      end
      if (i == DEPTH + 1) begin
        check("ready_a_edge17", rdya, 32'd1);
        check("ready_b_edge17", rdyb, 32'd1);
      end
    end
    ce0 = 1'b0; we0 = 1'b0;
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++)
      drive(1'b1, 1'b0, 4'(i), 8'h00, 1'b1, 1'b0, 4'(DEPTH - 1 - i), 8'h00);
    idle(3);
  endtask

  initial begin
    errors = 0; checks = 0; check_en = 1'b0;
    rst = 1'b1;
    ce0 = 1'b0; we0 = 1'b0; a0 = '0; d0 = '0;
    ce1 = 1'b0; we1 = 1'b0; a1 = '0; d1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_en = 1'b1;
    check("rst_ready", rdya, 32'd0);
    check("rst_q0_b", qb0, 32'd0);

    // Clear with a write attempt held while READY is low.
    release_and_clear(1'b1);
    read_all();
    drive(1'b1, 1'b0, 4'd2, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
    idle(3);
    check("inject_dropped_a", qa0, 32'h00);
    check("inject_dropped_b", qb0, 32'h00);

    // Cross-port write then read, latency 2 vs 3.
    drive(1'b1, 1'b1, 4'd3, 8'hA5, 1'b0, 1'b0, 4'd0, 8'h00);
    drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd3, 8'h00);
    idle(1);
    check("lat_a_early", qa1, 32'h00);
    idle(1);
    check("lat_a", qa1, 32'hA5);
    check("lat_b_early", qb1, 32'h00);
    idle(1);
    check("lat_b", qb1, 32'hA5);

    // Same-port read-during-write.
    drive(1'b1, 1'b1, 4'd5, 8'h11, 1'b0, 1'b0, 4'd0, 8'h00);
    drive(1'b1, 1'b0, 4'd5, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
    idle(3);
    drive(1'b1, 1'b1, 4'd5, 8'h3C, 1'b0, 1'b0, 4'd0, 8'h00);
    idle(2);
    check("rdw_read_first", qa0, 32'h11);
    idle(1);
    check("rdw_write_first", qb0, 32'h3C);

    // One port writes, the other reads the same address: reader gets old data.
    drive(1'b1, 1'b1, 4'd9, 8'h55, 1'b0, 1'b0, 4'd0, 8'h00);
    drive(1'b1, 1'b1, 4'd9, 8'h77, 1'b1, 1'b0, 4'd9, 8'h00);
    idle(3);
    check("xport_old_a", qa1, 32'h55);
    check("xport_old_b", qb1, 32'h55);
    drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd9, 8'h00);
    idle(3);
    check("xport_new_a", qa1, 32'h77);

    // Write-write collision on address 7.
    drive(1'b1, 1'b1, 4'd7, 8'h01, 1'b1, 1'b1, 4'd7, 8'h02);
    check("coll_before", colla, 32'd0);
    idle(1);
    check("coll_pulse_a", colla, 32'd1);
    check("coll_pulse_b", collb, 32'd1);
    idle(1);
    check("coll_end_a", colla, 32'd0);
    drive(1'b1, 1'b0, 4'd7, 8'h00, 1'b1, 1'b0, 4'd7, 8'h00);
    idle(3);
    check("coll_win_a0", qa0, 32'h01);
    check("coll_win_b1", qb1, 32'h01);

    // Both write different addresses: no collision.
    drive(1'b1, 1'b1, 4'd10, 8'hAA, 1'b1, 1'b1, 4'd11, 8'hBB);
    idle(1);
    check("nocoll_a", colla, 32'd0);
    drive(1'b1, 1'b0, 4'd11, 8'h00, 1'b1, 1'b0, 4'd10, 8'h00);
    idle(3);
    check("dual_rd_a0", qa0, 32'hBB);
    check("dual_rd_a1", qa1, 32'hAA);

    // Async reset after user traffic, then reset again mid-clear.
    rst = 1'b1;
    #1;
    check("async_q1_b", qb1, 32'h00);
    check("async_q0_a", qa0, 32'h00);
    check("async_ready", rdya, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(8);
    check("midclear_ready", rdya, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    release_and_clear(1'b0);
    read_all();
    drive(1'b1, 1'b0, 4'd7, 8'h00, 1'b1, 1'b0, 4'd9, 8'h00);
    idle(3);
    check("recleared_7", qb0, 32'h00);
    check("recleared_9", qa1, 32'h00);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
